// File: rtl/snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl
// Game-level sequencer sitting downstream of snake_body. Watches the head,
// body and apple pixel flags against the raster position, decides once per
// frame whether the snake ate an apple or crashed, and paces movement steps.
//
// Ports
//   VGA_clk      pixel clock, sole clock
//   reset        asynchronous active-low reset
//   xCount       raster column from the VGA controller
//   yCount       raster line from the VGA controller
//   snakeHead    head pixel flag (one VGA_clk behind the counts)
//   snakeBody    body pixel flag (one VGA_clk behind the counts)
//   applePix     apple pixel flag (one VGA_clk behind the counts)
//   direction    joystick direction, 5'b00111 means pause
//   go           level start / restart request
//   update       step strobe to snake_body, UPD_WIDTH cycles wide
//   start        1 = play, 0 = snake_body reinitialises positions
//   size         current snake length
//   score        apples eaten, saturating at 255
//   apple_eaten  single-cycle pulse to the apple generator
//   game_over    high while in DEAD
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | snake held at initial layout (start=0), waiting for go
// RUN   | playing; collisions/apples evaluated once per frame when armed
// DEAD  | snake frozen on screen, waiting for a rising edge of go
// ---------------------------------------------------------------------------
module snake_game_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BORDER          = 10,
  parameter int FRAMES_PER_STEP = 4,
  parameter int UPD_WIDTH       = 8,
  parameter int INIT_SIZE       = 3,
  parameter int MAX_SIZE        = 31
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic       snakeHead,
  input  logic       snakeBody,
  input  logic       applePix,
  input  logic [4:0] direction,
  input  logic       go,
  output logic       update,
  output logic       start,
  output logic [4:0] size,
  output logic [7:0] score,
  output logic       apple_eaten,
  output logic       game_over
);

  localparam int UW = (UPD_WIDTH > 2) ? $clog2(UPD_WIDTH) : 1;

  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    X_LO     = 10'(BORDER);
  localparam logic [9:0]    X_HI     = 10'(H_ACTIVE - BORDER);
  localparam logic [9:0]    Y_LO     = 10'(BORDER);
  localparam logic [9:0]    Y_HI     = 10'(V_ACTIVE - BORDER);
  localparam logic [3:0]    FPS_LAST = 4'(FRAMES_PER_STEP - 1);
  localparam logic [UW-1:0] UPD_LAST = UW'(UPD_WIDTH - 1);
  localparam logic [4:0]    INIT_SZ  = 5'(INIT_SIZE);
  localparam logic [4:0]    MAX_SZ   = 5'(MAX_SIZE);
  localparam logic [4:0]    DIR_PAUSE = 5'b00111;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  state_t state;

  logic [9:0]    xq, yq;
  logic          origin_q;
  logic          go_q;
  logic          exit_req;
  logic          hit_body, hit_wall, ate;
  logic          armed;
  logic [3:0]    frame_cnt;
  logic [UW-1:0] upd_cnt;

  logic origin, fs, in_active, in_border;
  logic body_now, wall_now, ate_now;
  logic paused, step_en, eval, collide, eat, step_fire;

  // Frame start is the first cycle the raster sits at the origin; a stalled
  // raster must not retrigger it.
  assign origin    = (xCount == 10'd0) && (yCount == 10'd0);
  assign fs        = origin && !origin_q;

  assign in_active = (xq < H_ACT) && (yq < V_ACT);
  assign in_border = (xq < X_LO) || (xq >= X_HI) || (yq < Y_LO) || (yq >= Y_HI);

  // Include the current cycle's pixel so a hit on the last pixel before fs
  // is not lost when the accumulators are cleared.
  assign body_now  = hit_body | (snakeHead & snakeBody);
  assign wall_now  = hit_wall | (snakeHead & in_active & in_border);
  assign ate_now   = ate | (snakeHead & applePix);

  assign paused    = (direction == DIR_PAUSE);
  assign step_en   = (state == IDLE) || ((state == RUN) && !paused);
  assign eval      = fs && (state == RUN) && armed;
  assign collide   = eval && (body_now || wall_now);
  assign eat       = eval && ate_now && !(body_now || wall_now);
  // A crashing frame must not launch a step, otherwise the snake would move
  // once more after death.
  assign step_fire = fs && step_en && (frame_cnt == FPS_LAST) && !collide;

  always_ff @(posedge VGA_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      xq          <= '0;
      yq          <= '0;
      origin_q    <= 1'b0;
      go_q        <= 1'b0;
      exit_req    <= 1'b0;
      hit_body    <= 1'b0;
      hit_wall    <= 1'b0;
      ate         <= 1'b0;
      armed       <= 1'b0;
      frame_cnt   <= '0;
      upd_cnt     <= '0;
      update      <= 1'b0;
      start       <= 1'b0;
      size        <= INIT_SZ;
      score       <= '0;
      apple_eaten <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      xq          <= xCount;
      yq          <= yCount;
      origin_q    <= origin;
      go_q        <= go;
      apple_eaten <= 1'b0;

      if (fs) begin
        hit_body <= 1'b0;
        hit_wall <= 1'b0;
        ate      <= 1'b0;
      end else begin
        hit_body <= body_now;
        hit_wall <= wall_now;
        ate      <= ate_now;
      end

      if (fs && step_en && !collide)
        frame_cnt <= (frame_cnt == FPS_LAST) ? 4'd0 : frame_cnt + 4'd1;

      // update pulse: down-counter loaded on launch, drops at terminal count
      if (step_fire) begin
        update  <= 1'b1;
        upd_cnt <= UPD_LAST;
        if (state == RUN)
          armed <= 1'b1;
      end else if (update) begin
        if (upd_cnt == '0)
          update <= 1'b0;
        else
          upd_cnt <= upd_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          start     <= 1'b0;
          size      <= INIT_SZ;
          game_over <= 1'b0;
          // Leaving IDLE flips start, so wait until no pulse is in flight.
          if (go && !update && !step_fire) begin
            state <= RUN;
            start <= 1'b1;
            score <= '0;
            armed <= 1'b0;
          end
        end
        RUN: begin
          if (collide) begin
            state     <= DEAD;
            game_over <= 1'b1;
          end else if (eat) begin
            apple_eaten <= 1'b1;
            score       <= (score == 8'hFF) ? score : score + 8'd1;
            size        <= (size >= MAX_SZ) ? MAX_SZ : size + 5'd1;
          end
        end
        DEAD: begin
          if (go && !go_q)
            exit_req <= 1'b1;
          if (exit_req && !update) begin
            state     <= IDLE;
            start     <= 1'b0;
            game_over <= 1'b0;
            size      <= INIT_SZ;
            exit_req  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule
